// File: rtl/att_pkg.sv
// Shared types and constants for the attenuator serial transmitter.
package att_pkg;

   localparam int ATT_WORD_WIDTH_DEF = 16;
   localparam int ATT_DIV_WIDTH      = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_HOLD,
      ST_LATCH
   } att_state_t;

   // Phase counter reload value; a divider of 0 behaves like 1.
   function automatic logic [ATT_DIV_WIDTH-1:0] divMinusOne(input logic [ATT_DIV_WIDTH-1:0] div);
      logic [ATT_DIV_WIDTH-1:0] result;
      if (div == '0) begin
         result = '0;
      end else begin
         result = div - 1'b1;
      end
      return result;
   endfunction

endpackage

// File: rtl/att_phase_cnt.sv
// Loadable down-counter that times each serial phase; o_tc marks the last cycle of a phase.
module att_phase_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_loadVal,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_count;

   // Parks at zero once expired so o_tc stays asserted while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadVal;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_tc = (r_count == '0);

endmodule

// File: rtl/att_serial_tx.sv
// Serialises one word to an attenuator: clocked bits on SI/CLK, then a latch pulse on LE.
module att_serial_tx #(
   parameter int WORD_WIDTH = att_pkg::ATT_WORD_WIDTH_DEF,
   parameter int MSB_FIRST  = 0
) (
   input  logic                           CLK_ATT,
   input  logic                           RST_ATT,
   input  logic [WORD_WIDTH-1:0]          ATT_WORD,
   input  logic [att_pkg::ATT_DIV_WIDTH-1:0] ATT_DIV,
   input  logic                           ATT_VALID,
   output logic                           ATT_READY,
   output logic                           BUSY,
   output logic                           DONE,
   output logic                           CLK,
   output logic                           SI,
   output logic                           LE
);

   import att_pkg::*;

   localparam int BCW = $clog2(WORD_WIDTH + 1);

   att_state_t r_state;
   att_state_t w_nextState;

   logic r_sclk;
   logic r_si;
   logic r_le;
   logic r_done;
   logic r_busy;
   logic r_ready;

   logic [WORD_WIDTH-1:0]    r_shift;
   logic [BCW-1:0]           r_bitCnt;
   logic [ATT_DIV_WIDTH-1:0] r_divM1;

   logic w_nextSclk;
   logic w_nextSi;
   logic w_nextLe;
   logic w_nextDone;
   logic w_capture;
   logic w_shiftEn;
   logic w_bitInc;
   logic w_cntLoad;
   logic w_tc;

   logic [ATT_DIV_WIDTH-1:0] w_loadDiv;
   logic [ATT_DIV_WIDTH-1:0] w_cntLoadVal;
   logic [WORD_WIDTH-1:0]    w_shifted;
   logic                     w_wordHead;
   logic                     w_shiftedHead;
   logic                     w_lastBit;

   // r_shift always holds the current bit at its head, so the next bit is the head after one shift.
   assign w_loadDiv     = divMinusOne(ATT_DIV);
   assign w_cntLoadVal  = w_capture ? w_loadDiv : r_divM1;
   assign w_shifted     = (MSB_FIRST != 0) ? {r_shift[WORD_WIDTH-2:0], 1'b0}
                                           : {1'b0, r_shift[WORD_WIDTH-1:1]};
   assign w_wordHead    = (MSB_FIRST != 0) ? ATT_WORD[WORD_WIDTH-1] : ATT_WORD[0];
   assign w_shiftedHead = (MSB_FIRST != 0) ? w_shifted[WORD_WIDTH-1] : w_shifted[0];
   assign w_lastBit     = (r_bitCnt == BCW'(WORD_WIDTH - 1));

   att_phase_cnt #(
      .WIDTH(ATT_DIV_WIDTH)
   ) u_phaseCnt (
      .clk      (CLK_ATT),
      .rst      (RST_ATT),
      .i_load   (w_cntLoad),
      .i_loadVal(w_cntLoadVal),
      .o_tc     (w_tc)
   );

   always_comb begin
      w_nextState = r_state;
      w_nextSclk  = r_sclk;
      w_nextSi    = r_si;
      w_nextLe    = r_le;
      w_nextDone  = 1'b0;
      w_capture   = 1'b0;
      w_shiftEn   = 1'b0;
      w_bitInc    = 1'b0;
      w_cntLoad   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (ATT_VALID) begin
               w_nextState = ST_LOW;
               w_capture   = 1'b1;
               w_cntLoad   = 1'b1;
               w_nextSclk  = 1'b0;
               w_nextSi    = w_wordHead;
               w_nextLe    = 1'b0;
            end
         end
         ST_LOW: begin
            if (w_tc) begin
               w_nextState = ST_HIGH;
               w_cntLoad   = 1'b1;
               w_nextSclk  = 1'b1;
            end
         end
         ST_HIGH: begin
            if (w_tc) begin
               w_cntLoad  = 1'b1;
               w_bitInc   = 1'b1;
               w_nextSclk = 1'b0;
               if (w_lastBit) begin
                  w_nextState = ST_HOLD;
               end else begin
                  w_nextState = ST_LOW;
                  w_shiftEn   = 1'b1;
                  w_nextSi    = w_shiftedHead;
               end
            end
         end
         ST_HOLD: begin
            if (w_tc) begin
               w_nextState = ST_LATCH;
               w_cntLoad   = 1'b1;
               w_nextLe    = 1'b1;
            end
         end
         ST_LATCH: begin
            if (w_tc) begin
               w_nextState = ST_IDLE;
               w_nextLe    = 1'b0;
               w_nextDone  = 1'b1;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
            w_nextSclk  = 1'b0;
            w_nextLe    = 1'b0;
         end
      endcase
   end

   // Status outputs are derived from the next state so they line up with the phase outputs.
   always_ff @(posedge CLK_ATT) begin
      if (RST_ATT) begin
         r_state <= ST_IDLE;
         r_sclk  <= 1'b0;
         r_si    <= 1'b0;
         r_le    <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_nextState;
         r_sclk  <= w_nextSclk;
         r_si    <= w_nextSi;
         r_le    <= w_nextLe;
         r_done  <= w_nextDone;
         r_busy  <= (w_nextState != ST_IDLE);
         r_ready <= (w_nextState == ST_IDLE);
      end
   end

   always_ff @(posedge CLK_ATT) begin
      if (RST_ATT) begin
         r_shift  <= '0;
         r_bitCnt <= '0;
         r_divM1  <= '0;
      end else if (w_capture) begin
         r_shift  <= ATT_WORD;
         r_bitCnt <= '0;
         r_divM1  <= w_loadDiv;
      end else begin
         if (w_shiftEn) begin
            r_shift <= w_shifted;
         end
         if (w_bitInc && (r_bitCnt != BCW'(WORD_WIDTH))) begin
            r_bitCnt <= r_bitCnt + 1'b1;
         end
      end
   end

   assign ATT_READY = r_ready;
   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign CLK       = r_sclk;
   assign SI        = r_si;
   assign LE        = r_le;

endmodule

// File: tb/tb_att_serial_tx.sv
// Scoreboard bench for att_serial_tx: one LSB-first and one MSB-first instance, randomized words and dividers.
module tb_att_serial_tx;

   localparam int W = 16;

   typedef struct {
      logic [W-1:0] word;
      int           d;
      int           base;
      bit           chained;
      bit           msb;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   logic [W-1:0] word0 = '0;
   logic [7:0]   div0  = '0;
   logic         valid0 = 1'b0;
   logic         ready0, busy0, done0, sclk0, si0, le0;

   logic [W-1:0] word1 = '0;
   logic [7:0]   div1  = '0;
   logic         valid1 = 1'b0;
   logic         ready1, busy1, done1, sclk1, si1, le1;

   exp_t expQ0[$];
   exp_t expQ1[$];

   int checks   = 0;
   int failures = 0;
   int timeouts = 0;
   bit finalReq = 1'b0;
   bit finalDone = 1'b0;
   bit lastKeep[2] = '{1'b0, 1'b0};

   int           riseCnt[2];
   int           riseCyc[2][W];
   logic [W-1:0] bitsSeen[2];
   int           leCnt[2];
   int           leFirst[2];
   int           busyCnt[2];
   int           lastDone[2];
   logic         prevClk[2];
   logic         prevRst = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   att_serial_tx #(.WORD_WIDTH(W), .MSB_FIRST(0)) dut0 (
      .CLK_ATT(clk), .RST_ATT(rst), .ATT_WORD(word0), .ATT_DIV(div0), .ATT_VALID(valid0),
      .ATT_READY(ready0), .BUSY(busy0), .DONE(done0), .CLK(sclk0), .SI(si0), .LE(le0)
   );

   att_serial_tx #(.WORD_WIDTH(W), .MSB_FIRST(1)) dut1 (
      .CLK_ATT(clk), .RST_ATT(rst), .ATT_WORD(word1), .ATT_DIV(div1), .ATT_VALID(valid1),
      .ATT_READY(ready1), .BUSY(busy1), .DONE(done1), .CLK(sclk1), .SI(si1), .LE(le1)
   );

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic clearRecord(input int idx);
      riseCnt[idx]  = 0;
      bitsSeen[idx] = '0;
      leCnt[idx]    = 0;
      leFirst[idx]  = -1;
      busyCnt[idx]  = 0;
      prevClk[idx]  = 1'b0;
   endtask

   // Reference: bit i of the send order sits under CLK rise i; timing is plain arithmetic in D and W.
   task automatic sampleDut(input int idx, input logic sclk, input logic si, input logic le,
                            input logic busy, input logic done, input logic ready);
      exp_t         e;
      logic [W-1:0] expBits;
      int           errs;
      if (prevRst) begin
         checkOutput($sformatf("d%0d_rst_clk", idx), sclk, 0);
         checkOutput($sformatf("d%0d_rst_si", idx), si, 0);
         checkOutput($sformatf("d%0d_rst_le", idx), le, 0);
         checkOutput($sformatf("d%0d_rst_done", idx), done, 0);
         checkOutput($sformatf("d%0d_rst_busy", idx), busy, 0);
         checkOutput($sformatf("d%0d_rst_ready", idx), ready, 1);
         if (idx == 0 && expQ0.size() != 0) void'(expQ0.pop_front());
         if (idx == 1 && expQ1.size() != 0) void'(expQ1.pop_front());
         clearRecord(idx);
         return;
      end
      if (sclk && !prevClk[idx]) begin
         if (riseCnt[idx] < W) begin
            riseCyc[idx][riseCnt[idx]] = cyc;
            bitsSeen[idx][riseCnt[idx]] = si;
         end
         riseCnt[idx]++;
      end
      if (le) begin
         if (leCnt[idx] == 0) leFirst[idx] = cyc;
         leCnt[idx]++;
      end
      if (busy) busyCnt[idx]++;
      prevClk[idx] = sclk;
      if (done) begin
         if ((idx == 0 && expQ0.size() == 0) || (idx == 1 && expQ1.size() == 0)) begin
            checkOutput($sformatf("d%0d_unexpected_done", idx), done, 0);
         end else begin
            e = (idx == 0) ? expQ0.pop_front() : expQ1.pop_front();
            errs = 0;
            for (int i = 0; i < W; i++) begin
               expBits[i] = e.msb ? e.word[W-1-i] : e.word[i];
               if (i < riseCnt[idx] && riseCyc[idx][i] != e.base + 1 + 2*e.d*i + e.d) errs++;
            end
            checkOutput($sformatf("d%0d_rise_count", idx), riseCnt[idx], W);
            checkOutput($sformatf("d%0d_si_bits w=%h", idx, e.word), bitsSeen[idx], expBits);
            checkOutput($sformatf("d%0d_rise_timing_errs", idx), errs, 0);
            checkOutput($sformatf("d%0d_le_first", idx), leFirst[idx], e.base + 2*e.d*W + e.d + 1);
            checkOutput($sformatf("d%0d_le_len", idx), leCnt[idx], e.d);
            checkOutput($sformatf("d%0d_busy_len", idx), busyCnt[idx], 2*e.d*W + 2*e.d);
            checkOutput($sformatf("d%0d_done_cycle", idx), cyc, e.base + 2*e.d*W + 2*e.d + 1);
            checkOutput($sformatf("d%0d_ready_at_done", idx), ready, 1);
            if (e.chained) checkOutput($sformatf("d%0d_accept_no_gap", idx), e.base, lastDone[idx]);
         end
         lastDone[idx] = cyc;
         clearRecord(idx);
      end
   endtask

   // Monitor: samples every output on the falling edge, independent of the stimulus thread.
   always @(negedge clk) begin
      if (finalReq && !finalDone) begin
         checkOutput("queue_drained", expQ0.size() + expQ1.size(), 0);
         checkOutput("stim_timeouts", timeouts, 0);
         finalDone = 1'b1;
      end
      sampleDut(0, sclk0, si0, le0, busy0, done0, ready0);
      sampleDut(1, sclk1, si1, le1, busy1, done1, ready1);
      prevRst = rst;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a word, waits for acceptance, then scrambles the inputs at cycle 10 of the transfer.
   task automatic applyStimulus(input int idx, input logic [W-1:0] word, input logic [7:0] div,
                                input bit keep, output int base);
      exp_t e;
      int   guard = 0;
      if (idx == 0) begin word0 = word; div0 = div; valid0 = 1'b1; end
      else          begin word1 = word; div1 = div; valid1 = 1'b1; end
      while (((idx == 0) ? !ready0 : !ready1) && guard < 2000) begin
         tick();
         guard++;
      end
      base = cyc;
      if (guard >= 2000) begin
         timeouts++;
         if (idx == 0) valid0 = 1'b0; else valid1 = 1'b0;
         return;
      end
      e.word    = word;
      e.d       = (div == 0) ? 1 : int'(div);
      e.base    = cyc;
      e.chained = lastKeep[idx];
      e.msb     = (idx == 1);
      if (idx == 0) expQ0.push_back(e); else expQ1.push_back(e);
      lastKeep[idx] = keep;
      tick();
      if (!keep) begin
         if (idx == 0) valid0 = 1'b0; else valid1 = 1'b0;
      end
      repeat (9) tick();
      if (idx == 0) begin word0 = W'($urandom); div0 = 8'($urandom); end
      else          begin word1 = W'($urandom); div1 = 8'($urandom); end
   endtask

   task automatic drain();
      int guard = 0;
      while ((expQ0.size() + expQ1.size()) != 0 && guard < 5000) begin
         tick();
         guard++;
      end
   endtask

   initial begin
      int base;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      applyStimulus(0, 16'h00A5, 8'd4, 1'b0, base);
      applyStimulus(0, 16'hFFFF, 8'd0, 1'b0, base);
      applyStimulus(0, 16'h1234, 8'd1, 1'b1, base);
      applyStimulus(0, 16'h5678, 8'd1, 1'b0, base);
      applyStimulus(1, 16'h8001, 8'd2, 1'b0, base);
      drain();

      applyStimulus(0, W'($urandom), 8'd4, 1'b0, base);
      while (cyc < base + 40) tick();
      rst    = 1'b1;
      valid0 = 1'b1;
      word0  = W'($urandom);
      tick();
      rst    = 1'b0;
      valid0 = 1'b0;
      tick();

      for (int n = 0; n < 20; n++) begin
         applyStimulus(0, W'($urandom), 8'($urandom_range(0, 5)), (n != 19) && ($urandom_range(0, 1) == 1), base);
      end
      for (int n = 0; n < 4; n++) begin
         applyStimulus(1, W'($urandom), 8'($urandom_range(0, 3)), 1'b0, base);
      end
      drain();
      repeat (2) tick();

      finalReq = 1'b1;
      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
